// File: rtl/bus_region_decoder.sv
// Memory-map decoder and bus sequencer: base/mask region hits, per-region wait states,
// registered read return and sticky decode error. Define BUS_SHADOW_REG_EN for the shadow register.
module bus_region_decoder #(
  parameter int REGIONS = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int WS_W    = 2,
  parameter logic [REGIONS*ADDR_W-1:0] BASE = {16'hE000, 16'h7F00, 16'h4000, 16'h0000},
  parameter logic [REGIONS*ADDR_W-1:0] MASK = {16'hE000, 16'hFFF0, 16'hE000, 16'hE000},
  parameter logic [REGIONS*WS_W-1:0]   WAIT = {2'd3, 2'd0, 2'd1, 2'd0},
  parameter logic [DATA_W-1:0]         DEFAULT_DATA = 8'h00,
  parameter logic [ADDR_W-1:0]         SHADOW_BASE  = 16'h6000,
  parameter logic [ADDR_W-1:0]         SHADOW_MASK  = 16'hFC00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpuAddr,
  input  logic                      cpuStrobe,
  input  logic                      cpuWrite,
  input  logic [DATA_W-1:0]         cpuDataWrite,
  output logic [DATA_W-1:0]         cpuDataRead,
  output logic                      cpuReady,
  output logic [REGIONS-1:0]        regStrobe,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         regAddr,
  output logic [DATA_W-1:0]         regDataWrite,
  input  logic [REGIONS*DATA_W-1:0] regReadData,
  output logic                      decodeError,
  input  logic                      errClear,
  output logic [DATA_W-1:0]         shadowOut
);

  localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;
  localparam int LO_W  = DATA_W / 2;
  localparam int HI_W  = DATA_W - LO_W;

`ifdef BUS_SHADOW_REG_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WS_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;

  logic [REGIONS-1:0]  hit;
  logic                hit_any;
  logic [IDX_W-1:0]    hit_idx;
  logic                shadow_hit;
  logic [WS_W-1:0]     wait_sel;
  logic [DATA_W-1:0]   read_sel;

  genvar gi;
  generate
    for (gi = 0; gi < REGIONS; gi++) begin : g_hit
      assign hit[gi] = (cpuAddr & MASK[gi*ADDR_W +: ADDR_W]) == BASE[gi*ADDR_W +: ADDR_W];
      assign regStrobe[gi] = (state_q == ACCESS) && (idx_q == IDX_W'(gi));
    end
  endgenerate

  // Scan downwards so the lowest-index hit is the last assignment and wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign shadow_hit = SHADOW_EN && ((cpuAddr & SHADOW_MASK) == SHADOW_BASE);
  assign wait_sel   = WAIT[hit_idx*WS_W +: WS_W];
  assign read_sel   = regReadData[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q & ~errClear;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (cpuStrobe) begin
          addr_d  = cpuAddr;
          write_d = cpuWrite;
          wdata_d = cpuDataWrite;
          idx_d   = hit_idx;
          if (shadow_hit) begin
            if (cpuWrite) shadow_d = {cpuDataWrite[DATA_W-1 -: HI_W], {LO_W{1'b0}}};
            else          rdata_d  = shadow_q;
            state_d = DONE;
          end else if (hit_any) begin
            cnt_d   = wait_sel;
            state_d = ACCESS;
          end else begin
            // Set overrides a simultaneous errClear.
            rdata_d = DEFAULT_DATA;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!write_q) rdata_d = read_sel;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  assign cpuReady     = (state_q == DONE);
  assign regWrite     = (state_q == ACCESS) && write_q;
  assign cpuDataRead  = rdata_q;
  assign regAddr      = addr_q;
  assign regDataWrite = wdata_q;
  assign decodeError  = err_q;
  assign shadowOut    = shadow_q;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Randomized self-checking bench for bus_region_decoder against a memory-map reference model.
module tb_bus_region_decoder;

  logic        clk;
  logic        reset;
  logic [15:0] cpuAddr;
  logic        cpuStrobe;
  logic        cpuWrite;
  logic [7:0]  cpuDataWrite;
  logic [31:0] regReadData;
  logic        errClear;

  logic [7:0]  cpuDataRead, ovl_cpuDataRead;
  logic        cpuReady, ovl_cpuReady;
  logic [3:0]  regStrobe, ovl_regStrobe;
  logic        regWrite, ovl_regWrite;
  logic [15:0] regAddr, ovl_regAddr;
  logic [7:0]  regDataWrite, ovl_regDataWrite;
  logic        decodeError, ovl_decodeError;
  logic [7:0]  shadowOut, ovl_shadowOut;

  bus_region_decoder dut (
    .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuStrobe(cpuStrobe),
    .cpuWrite(cpuWrite), .cpuDataWrite(cpuDataWrite), .cpuDataRead(cpuDataRead),
    .cpuReady(cpuReady), .regStrobe(regStrobe), .regWrite(regWrite),
    .regAddr(regAddr), .regDataWrite(regDataWrite), .regReadData(regReadData),
    .decodeError(decodeError), .errClear(errClear), .shadowOut(shadowOut)
  );

  // Region 2 widened to match every address, so it overlaps region 1.
  bus_region_decoder #(
    .BASE({16'hE000, 16'h0000, 16'h4000, 16'h0000}),
    .MASK({16'hE000, 16'h0000, 16'hE000, 16'hE000})
  ) ovl (
    .clk(clk), .reset(reset), .cpuAddr(cpuAddr), .cpuStrobe(cpuStrobe),
    .cpuWrite(cpuWrite), .cpuDataWrite(cpuDataWrite), .cpuDataRead(ovl_cpuDataRead),
    .cpuReady(ovl_cpuReady), .regStrobe(ovl_regStrobe), .regWrite(ovl_regWrite),
    .regAddr(ovl_regAddr), .regDataWrite(ovl_regDataWrite), .regReadData(regReadData),
    .decodeError(ovl_decodeError), .errClear(errClear), .shadowOut(ovl_shadowOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  logic [15:0] m_base [4] = '{16'h0000, 16'h4000, 16'h7F00, 16'hE000};
  logic [15:0] m_mask [4] = '{16'hE000, 16'hE000, 16'hFFF0, 16'hE000};
  int          m_wait [4] = '{0, 1, 0, 3};
  logic [7:0]  m_rdata  = 8'h00;
  logic        m_err    = 1'b0;
  logic [7:0]  m_shadow = 8'h00;
  logic [3:0]  ovl_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // -2 = shadow register, -1 = unmapped, otherwise the first matching region.
  function automatic int m_decode(input logic [15:0] a);
`ifdef BUS_SHADOW_REG_EN
    if ((a & 16'hFC00) == 16'h6000) return -2;
`endif
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  // Called just after a negedge; strobe stays high with junk inputs while busy.
  task automatic do_access(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                           input logic clr, input logic [31:0] rdbus);
    int         r;
    int         lat;
    int         exp_lat;
    int         strobe_cycles;
    logic [3:0] strobe_or;
    logic       rw_or;
    logic       got;
    r = m_decode(a);
    regReadData  = rdbus;
    cpuAddr      = a;
    cpuWrite     = wr;
    cpuDataWrite = wd;
    errClear     = clr;
    cpuStrobe    = 1'b1;
    @(posedge clk);
    m_err = (m_err & ~clr) | (r == -1);
    if (r >= 0) begin
      if (!wr) m_rdata = rdbus[r*8 +: 8];
    end else if (r == -1) begin
      m_rdata = 8'h00;
    end else begin
      if (wr) m_shadow = {wd[7:4], 4'h0};
      else    m_rdata  = m_shadow;
    end
    exp_lat = (r >= 0) ? m_wait[r] + 2 : 1;
    lat = 0; got = 1'b0; strobe_cycles = 0; strobe_or = '0; rw_or = 1'b0; ovl_seen = '0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        errClear     = 1'b0;
        cpuAddr      = 16'($urandom);
        cpuDataWrite = 8'($urandom);
        cpuWrite     = 1'($urandom);
      end
      if (regStrobe != 4'b0) begin
        strobe_cycles++;
        rw_or = rw_or | regWrite;
      end
      strobe_or = strobe_or | regStrobe;
      ovl_seen  = ovl_seen | ovl_regStrobe;
      if (cpuReady) begin
        got       = 1'b1;
        lat       = c;
        cpuStrobe = 1'b0;
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", lat, exp_lat);
    check("strobe_value", 32'(strobe_or), (r >= 0) ? (32'd1 << r) : 32'd0);
    check("strobe_cycles", strobe_cycles, (r >= 0) ? m_wait[r] + 1 : 0);
    check("reg_write", 32'(rw_or), (r >= 0) ? 32'(wr) : 32'd0);
    check("read_data", 32'(cpuDataRead), 32'(m_rdata));
    check("reg_addr", 32'(regAddr), 32'(a));
    check("reg_wdata", 32'(regDataWrite), 32'(wd));
    check("decode_error", 32'(decodeError), 32'(m_err));
    check("shadow_out", 32'(shadowOut), 32'(m_shadow));
    @(negedge clk);
    check("ready_pulse", 32'(cpuReady), 32'd0);
    $display("txn %0d addr=%h wr=%0d wd=%h region=%0d lat=%0d rdata=%h err=%0d",
             n_txn, a, wr, wd, r, lat, cpuDataRead, decodeError);
    n_txn++;
  endtask

  task automatic clear_error();
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
    m_err = 1'b0;
    check("err_clear_alone", 32'(decodeError), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    int          kind;
    int          seen_ready;
    reset = 1'b0; cpuAddr = '0; cpuStrobe = 1'b0; cpuWrite = 1'b0;
    cpuDataWrite = '0; regReadData = '0; errClear = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_strobe", 32'(regStrobe), 32'd0);
    check("rst_ready", 32'(cpuReady), 32'd0);
    check("rst_rdata", 32'(cpuDataRead), 32'd0);
    check("rst_error", 32'(decodeError), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Overlap: region 1 must beat the catch-all region 2 in the widened map.
    do_access(16'h4000, 1'b0, 8'h00, 1'b0, 32'h44332211);
    check("overlap_strobe", 32'(ovl_seen), 32'h2);

    do_access(16'h0123, 1'b0, 8'h00, 1'b0, 32'h112233A5);
    check("read_0123", 32'(cpuDataRead), 32'hA5);
    do_access(16'hE010, 1'b1, 8'h3C, 1'b0, 32'h55667788);
    check("write_e010_wdata", 32'(regDataWrite), 32'h3C);
    do_access(16'h9000, 1'b0, 8'h00, 1'b0, 32'hFFFFFFFF);
    check("miss_error", 32'(decodeError), 32'd1);
    do_access(16'h9000, 1'b0, 8'h00, 1'b1, 32'hFFFFFFFF);
    check("miss_with_clear", 32'(decodeError), 32'd1);
    clear_error();
    do_access(16'hA000, 1'b0, 8'h00, 1'b0, 32'h0);
    do_access(16'h7F05, 1'b0, 8'h00, 1'b0, 32'h00C30000);

    // Reset during the second wait cycle of a region-3 read.
    regReadData = 32'hDEADBEEF;
    cpuAddr = 16'hE004; cpuWrite = 1'b0; cpuStrobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpuStrobe = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    m_rdata = 8'h00; m_err = 1'b0; m_shadow = 8'h00;
    check("abort_strobe", 32'(regStrobe), 32'd0);
    check("abort_ready", 32'(cpuReady), 32'd0);
    check("abort_rdata", 32'(cpuDataRead), 32'd0);
    check("abort_addr", 32'(regAddr), 32'd0);
    check("abort_error", 32'(decodeError), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpuReady) seen_ready++;
    end
    check("abort_no_ready", seen_ready, 0);
    do_access(16'h7F03, 1'b0, 8'h00, 1'b0, 32'h005A0000);
    check("read_7f03", 32'(cpuDataRead), 32'h5A);

`ifdef BUS_SHADOW_REG_EN
    do_access(16'h6001, 1'b1, 8'hB7, 1'b0, 32'h0);
    check("shadow_write", 32'(shadowOut), 32'hB0);
    do_access(16'h63FF, 1'b0, 8'h00, 1'b0, 32'h12345678);
    check("shadow_read", 32'(cpuDataRead), 32'hB0);
`endif

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       a = 16'($urandom);
        1:       a = 16'h6000 | 16'($urandom_range(0, 16'h03FF));
        2:       a = 16'h7F00 | 16'($urandom_range(0, 31));
        default: a = m_base[kind - 2] | 16'($urandom_range(0, 16'h1FFF));
      endcase
      do_access(a, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 7) == 0) clear_error();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
